kinase_assay_sequencer: RTL and testbench

//   Sequences the valves and pumps of the kinase activity chip through one assay: load reagent,
//   mix, incubate, dispense to an outlet, and optionally flush. It sits between the host/test

---
 rtl/kinase_assay_sequencer_pkg.sv | 42 ++++
 rtl/kinase_assay_sequencer_if.sv | 28 ++
 rtl/kinase_assay_sequencer_pump_phaser.sv | 69 ++++++
 rtl/kinase_assay_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_kinase_assay_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/kinase_assay_sequencer_pkg.sv
// Shared constants for the kinase assay sequencer: state encodings, valve
// indices, pump phase patterns and the safe (isolated) pad values.
package kinase_seq_pkg;

    localparam int unsigned CTRL_A_W = 13;
    localparam int unsigned CTRL_S_W = 4;
    localparam int unsigned PUMP_A_W = 3;
    localparam int unsigned PUMP_B_W = 2;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned STATE_W  = 3;

    // Sequencer states
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD     = 3'd1;
    localparam logic [STATE_W-1:0] ST_MIX      = 3'd2;
    localparam logic [STATE_W-1:0] ST_INCUBATE = 3'd3;
    localparam logic [STATE_W-1:0] ST_OUTPUT   = 3'd4;
    localparam logic [STATE_W-1:0] ST_FLUSH    = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd6;

    // Valve bit positions inside ctrl_a
    localparam int unsigned INLET_BASE  = 0;
    localparam int unsigned OUTLET_BASE = 3;
    localparam int unsigned MIX_ISO     = 7;

    // Peristaltic phase patterns; element 0 is the first phase after state entry
    localparam logic [2:0][PUMP_A_W-1:0] PUMP_A_PAT = {3'b101, 3'b011, 3'b110};
    localparam logic [1:0][PUMP_B_W-1:0] PUMP_B_PAT = {2'b10, 2'b01};

    // Safe / isolated pad values and the all-open flush pattern
    localparam logic [CTRL_A_W-1:0] CTRL_A_SAFE  = 13'h1FFF;
    localparam logic [CTRL_A_W-1:0] CTRL_A_FLUSH = 13'h1F00;
    localparam logic [CTRL_S_W-1:0] CTRL_S_SAFE  = 4'h0;
    localparam logic [PUMP_A_W-1:0] PUMP_A_SAFE  = 3'b111;
    localparam logic [PUMP_B_W-1:0] PUMP_B_SAFE  = 2'b11;

    // One-hot outlet select
    function automatic logic [CTRL_S_W-1:0] outlet_onehot(input logic [SEL_W-1:0] sel);
        return CTRL_S_W'(1) << sel;
    endfunction

endpackage

// File: rtl/kinase_assay_sequencer_if.sv
// Host <-> sequencer bundle: run control in, chip pad drives and status out.
//   master: host/test controller (drives start, abort, in_sel, out_sel)
//   slave : sequencer (drives busy, done, err, ctrl_a, ctrl_s, pump_a, pump_b)
interface kinase_assay_sequencer_if;
    import kinase_seq_pkg::*;

    logic                start;
    logic                abort;
    logic [SEL_W-1:0]    in_sel;
    logic [SEL_W-1:0]    out_sel;
    logic                busy;
    logic                done;
    logic                err;
    logic [CTRL_A_W-1:0] ctrl_a;
    logic [CTRL_S_W-1:0] ctrl_s;
    logic [PUMP_A_W-1:0] pump_a;
    logic [PUMP_B_W-1:0] pump_b;

    modport master (
        output start, abort, in_sel, out_sel,
        input  busy, done, err, ctrl_a, ctrl_s, pump_a, pump_b
    );

    modport slave (
        input  start, abort, in_sel, out_sel,
        output busy, done, err, ctrl_a, ctrl_s, pump_a, pump_b
    );
endinterface

// File: rtl/kinase_assay_sequencer_pump_phaser.sv
// pump_phaser: steps a pump through PHASES phases, each held DIV cycles, and
// counts strokes (one stroke = all phases once).
//   clk, rst_n     clock, async active-low reset
//   clear          return to phase 0 / zero strokes on the next edge (wins over enable)
//   enable         advance the divider
//   strokes        number of strokes for the current run
//   phase_nxt_c    phase index that will be current after the next edge
//   stroke_done_c  high in the cycle that completes the final stroke
module pump_phaser #(
    parameter  int unsigned PHASES    = 3,
    parameter  int unsigned DIV       = 1,
    parameter  int unsigned STROKES_W = 1,
    localparam int unsigned PH_W      = (PHASES > 1) ? $clog2(PHASES) : 1,
    localparam int unsigned DIV_W     = $clog2(DIV + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [STROKES_W-1:0] strokes,
    output logic [PH_W-1:0]      phase_nxt_c,
    output logic                 stroke_done_c
);

    logic [DIV_W-1:0]     div_q,    div_d;
    logic [PH_W-1:0]      phase_q,  phase_d;
    logic [STROKES_W-1:0] stroke_q, stroke_d;

    // Divider, phase and stroke counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            phase_q  <= '0;
            stroke_q <= '0;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            stroke_q <= stroke_d;
        end
    end

    // Next counter values; the owner registers its pads from phase_nxt_c
    always_comb begin
        div_d         = div_q;
        phase_d       = phase_q;
        stroke_d      = stroke_q;
        stroke_done_c = 1'b0;
        if (clear) begin
            div_d    = '0;
            phase_d  = '0;
            stroke_d = '0;
        end else if (enable) begin
            if (div_q == DIV_W'(DIV - 1)) begin
                div_d = '0;
                if (phase_q == PH_W'(PHASES - 1)) begin
                    phase_d       = '0;
                    stroke_d      = stroke_q + STROKES_W'(1);
                    stroke_done_c = (stroke_q == strokes - STROKES_W'(1));
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        phase_nxt_c = phase_d;
    end

endmodule

// File: rtl/kinase_assay_sequencer.sv
// kinase_assay_sequencer: runs one assay (LOAD, MIX, INCUBATE, OUTPUT,
// optional FLUSH) per start request and keeps the chip isolated otherwise.
// Optional feature macro: KINASE_SEQ_FLUSH_EN adds the FLUSH state after OUTPUT.
//   clk, rst_n  clock, async active-low reset
//   bus (slave) start/abort/in_sel/out_sel in; busy/done/err and the
//               ctrl_a/ctrl_s/pump_a/pump_b pad drives out, all registered
module kinase_assay_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int unsigned PUMP_DIV        = 1000,
    parameter int unsigned LOAD_STROKES    = 16,
    parameter int unsigned MIX_STROKES     = 64,
    parameter int unsigned INCUBATE_CYCLES = 100000,
    parameter int unsigned OUT_STROKES     = 16,
    parameter int unsigned FLUSH_CYCLES    = 5000
) (
    input logic                      clk,
    input logic                      rst_n,
    kinase_assay_sequencer_if.slave  bus
);

    localparam int unsigned MAX_LM = (LOAD_STROKES > MIX_STROKES) ? LOAD_STROKES : MIX_STROKES;
    localparam int unsigned MAX_STROKES = (MAX_LM > OUT_STROKES) ? MAX_LM : OUT_STROKES;
    localparam int unsigned STROKES_W = $clog2(MAX_STROKES + 1);
    // One timer serves INCUBATE and FLUSH, sized for the longer of the two
    localparam int unsigned CYC_MAX = (INCUBATE_CYCLES > FLUSH_CYCLES) ? INCUBATE_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CYC_W = $clog2(CYC_MAX + 1);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [SEL_W-1:0]    in_sel_q, in_sel_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;

    logic [CTRL_A_W-1:0] ctrl_a_q, ctrl_a_d;
    logic [CTRL_S_W-1:0] ctrl_s_q, ctrl_s_d;
    logic [PUMP_A_W-1:0] pump_a_q, pump_a_d;
    logic [PUMP_B_W-1:0] pump_b_q, pump_b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                 pa_en, pb_en;
    logic [1:0]           pa_phase;
    logic [0:0]           pb_phase;
    logic                 pa_done, pb_done;
    logic [STROKES_W-1:0] pa_strokes;
    logic [3:0]           in_idx, out_idx;

    // Pumps idle (held at phase 0) outside the states that drive them
    assign pa_en      = (state_q == ST_LOAD) || (state_q == ST_OUTPUT);
    assign pb_en      = (state_q == ST_MIX);
    assign pa_strokes = (state_q == ST_LOAD) ? STROKES_W'(LOAD_STROKES) : STROKES_W'(OUT_STROKES);

    pump_phaser #(
        .PHASES    (3),
        .DIV       (PUMP_DIV),
        .STROKES_W (STROKES_W)
    ) u_pump_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (!pa_en),
        .enable        (pa_en),
        .strokes       (pa_strokes),
        .phase_nxt_c   (pa_phase),
        .stroke_done_c (pa_done)
    );

    pump_phaser #(
        .PHASES    (2),
        .DIV       (PUMP_DIV),
        .STROKES_W (STROKES_W)
    ) u_pump_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (!pb_en),
        .enable        (pb_en),
        .strokes       (STROKES_W'(MIX_STROKES)),
        .phase_nxt_c   (pb_phase),
        .stroke_done_c (pb_done)
    );

    // State, run selection, timer and registered pads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            in_sel_q  <= '0;
            out_sel_q <= '0;
            cyc_q     <= '0;
            ctrl_a_q  <= CTRL_A_SAFE;
            ctrl_s_q  <= CTRL_S_SAFE;
            pump_a_q  <= PUMP_A_SAFE;
            pump_b_q  <= PUMP_B_SAFE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_sel_q  <= in_sel_d;
            out_sel_q <= out_sel_d;
            cyc_q     <= cyc_d;
            ctrl_a_q  <= ctrl_a_d;
            ctrl_s_q  <= ctrl_s_d;
            pump_a_q  <= pump_a_d;
            pump_b_q  <= pump_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state, then pads decoded from the next state so they switch with it
    always_comb begin
        state_d   = state_q;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
        cyc_d     = '0;
        err_d     = 1'b0;
        ctrl_a_d  = CTRL_A_SAFE;
        ctrl_s_d  = CTRL_S_SAFE;
        pump_a_d  = PUMP_A_SAFE;
        pump_b_d  = PUMP_B_SAFE;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.in_sel == SEL_W'(3)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_LOAD;
                        in_sel_d  = bus.in_sel;
                        out_sel_d = bus.out_sel;
                    end
                end
            end
            ST_LOAD: begin
                if (pa_done) state_d = ST_MIX;
            end
            ST_MIX: begin
                if (pb_done) state_d = ST_INCUBATE;
            end
            ST_INCUBATE: begin
                if (cyc_q == CYC_W'(INCUBATE_CYCLES - 1)) state_d = ST_OUTPUT;
                else cyc_d = cyc_q + CYC_W'(1);
            end
            ST_OUTPUT: begin
`ifdef KINASE_SEQ_FLUSH_EN
                if (pa_done) state_d = ST_FLUSH;
`else
                if (pa_done) state_d = ST_DONE;
`endif
            end
`ifdef KINASE_SEQ_FLUSH_EN
            ST_FLUSH: begin
                if (cyc_q == CYC_W'(FLUSH_CYCLES - 1)) state_d = ST_DONE;
                else cyc_d = cyc_q + CYC_W'(1);
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort beats everything, including a start seen in IDLE
        if (bus.abort) state_d = ST_IDLE;

        in_idx  = 4'(INLET_BASE) + 4'(in_sel_d);
        out_idx = 4'(OUTLET_BASE) + 4'(out_sel_d);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);

        case (state_d)
            ST_LOAD: begin
                ctrl_a_d[in_idx] = 1'b0;
                pump_a_d         = PUMP_A_PAT[pa_phase];
            end
            ST_MIX: begin
                ctrl_a_d[MIX_ISO] = 1'b0;
                pump_b_d          = PUMP_B_PAT[pb_phase];
            end
            ST_OUTPUT: begin
                ctrl_a_d[out_idx] = 1'b0;
                ctrl_s_d          = outlet_onehot(out_sel_d);
                pump_a_d          = PUMP_A_PAT[pa_phase];
            end
`ifdef KINASE_SEQ_FLUSH_EN
            ST_FLUSH: begin
                ctrl_a_d = CTRL_A_FLUSH;
                pump_a_d = '0;
                pump_b_d = '0;
            end
`endif
            default: ;
        endcase
    end

    assign bus.ctrl_a = ctrl_a_q;
    assign bus.ctrl_s = ctrl_s_q;
    assign bus.pump_a = pump_a_q;
    assign bus.pump_b = pump_b_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_kinase_assay_sequencer.sv
// Directed, table-driven bench for kinase_assay_sequencer with small timing
// parameters; each table row is one clock of inputs plus the pads expected
// after that edge. Build with KINASE_SEQ_FLUSH_EN to cover the flush variant.
module tb_kinase_assay_sequencer;
    import kinase_seq_pkg::*;

    localparam int unsigned PUMP_DIV        = 2;
    localparam int unsigned LOAD_STROKES    = 2;
    localparam int unsigned MIX_STROKES     = 1;
    localparam int unsigned INCUBATE_CYCLES = 5;
    localparam int unsigned OUT_STROKES     = 1;
    localparam int unsigned FLUSH_CYCLES    = 3;

`ifdef KINASE_SEQ_FLUSH_EN
    localparam int unsigned EXP_BUSY = 31;
`else
    localparam int unsigned EXP_BUSY = 28;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kinase_assay_sequencer_if bus();

    kinase_assay_sequencer #(
        .PUMP_DIV        (PUMP_DIV),
        .LOAD_STROKES    (LOAD_STROKES),
        .MIX_STROKES     (MIX_STROKES),
        .INCUBATE_CYCLES (INCUBATE_CYCLES),
        .OUT_STROKES     (OUT_STROKES),
        .FLUSH_CYCLES    (FLUSH_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [1:0]  in_sel;
        logic [1:0]  out_sel;
        logic [12:0] ctrl_a;
        logic [3:0]  ctrl_s;
        logic [2:0]  pump_a;
        logic [1:0]  pump_b;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Hand-derived pump sequences seen after each edge inside a state
    logic [2:0] pa_seq [6] = '{3'b110, 3'b110, 3'b011, 3'b011, 3'b101, 3'b101};
    logic [1:0] pb_seq [4] = '{2'b01, 2'b01, 2'b10, 2'b10};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic void push(input logic st, input logic ab, input logic [1:0] is,
                                 input logic [1:0] os, input logic [12:0] ca, input logic [3:0] cs,
                                 input logic [2:0] pa, input logic [1:0] pb, input logic bz,
                                 input logic dn, input logic er);
        vec_t v;
        v.start = st;  v.abort = ab;  v.in_sel = is;  v.out_sel = os;
        v.ctrl_a = ca; v.ctrl_s = cs; v.pump_a = pa;  v.pump_b = pb;
        v.busy = bz;   v.done = dn;   v.err = er;
        vecs.push_back(v);
    endfunction

    // Idle cycle with safe pads
    function automatic void push_idle();
        push(1'b0, 1'b0, 2'd0, 2'd0, 13'h1FFF, 4'h0, 3'b111, 2'b11, 1'b0, 1'b0, 1'b0);
    endfunction

    // start + 12 LOAD cycles; selects are scrambled after the start cycle
    function automatic void push_load(input logic [1:0] is, input logic [1:0] os, input logic [12:0] ca);
        for (int i = 0; i < 12; i++)
            push(i == 0, 1'b0, (i == 0) ? is : 2'd3, (i == 0) ? os : ~os,
                 ca, 4'h0, pa_seq[i % 6], 2'b11, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic void push_mix(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b0, 2'd3, 2'd1, 13'h1F7F, 4'h0, 3'b111, pb_seq[i], 1'b1, 1'b0, 1'b0);
    endfunction

    // Full normal run ending with one idle row
    function automatic void push_run(input logic [1:0] is, input logic [1:0] os, input logic [12:0] ca_load,
                                     input logic [12:0] ca_out, input logic [3:0] cs_out);
        push_load(is, os, ca_load);
        push_mix(4);
        for (int i = 0; i < 5; i++)   // start in the 2nd INCUBATE cycle must be ignored
            push(i == 1, 1'b0, 2'd0, 2'd0, 13'h1FFF, 4'h0, 3'b111, 2'b11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            push(1'b0, 1'b0, 2'd3, 2'd0, ca_out, cs_out, pa_seq[i], 2'b11, 1'b1, 1'b0, 1'b0);
`ifdef KINASE_SEQ_FLUSH_EN
        for (int i = 0; i < 3; i++)
            push(1'b0, 1'b0, 2'd0, 2'd0, 13'h1F00, 4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0);
`endif
        push(1'b0, 1'b0, 2'd0, 2'd0, 13'h1FFF, 4'h0, 3'b111, 2'b11, 1'b1, 1'b1, 1'b0);
        push_idle();
    endfunction

    task automatic check_pads(input string tag, input logic [12:0] ca, input logic [2:0] pa,
                              input logic [1:0] pb, input logic bz);
        check({tag, " ctrl_a"}, 16'(bus.ctrl_a), 16'(ca));
        check({tag, " ctrl_s"}, 16'(bus.ctrl_s), 16'(4'h0));
        check({tag, " pump_a"}, 16'(bus.pump_a), 16'(pa));
        check({tag, " pump_b"}, 16'(bus.pump_b), 16'(pb));
        check({tag, " busy"},   16'(bus.busy),   16'(bz));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_sel = 2'd0; bus.out_sel = 2'd0;

        // Vector table
        push_run(2'd1, 2'd2, 13'h1FFD, 13'h1FDF, 4'b0100);
        push(1'b1, 1'b0, 2'd3, 2'd0, 13'h1FFF, 4'h0, 3'b111, 2'b11, 1'b0, 1'b0, 1'b1); // illegal inlet
        push_idle();
        push(1'b1, 1'b1, 2'd0, 2'd1, 13'h1FFF, 4'h0, 3'b111, 2'b11, 1'b0, 1'b0, 1'b0); // abort beats start
        push_idle();
        push_load(2'd0, 2'd0, 13'h1FFE);
        push_mix(3);
        push(1'b0, 1'b1, 2'd0, 2'd0, 13'h1FFF, 4'h0, 3'b111, 2'b11, 1'b0, 1'b0, 1'b0); // abort in MIX
        push_idle();
        push_run(2'd2, 2'd3, 13'h1FFB, 13'h1FBF, 4'b1000);
        push_run(2'd0, 2'd0, 13'h1FFE, 13'h1FF7, 4'b0001);

        // Reset state, held and released
        repeat (2) @(negedge clk);
        check_pads("in_reset", 13'h1FFF, 3'b111, 2'b11, 1'b0);
        check("in_reset done", 16'(bus.done), 16'(0));
        check("in_reset err", 16'(bus.err), 16'(0));
        rst_n = 1'b1;
        step();
        check_pads("post_reset", 13'h1FFF, 3'b111, 2'b11, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start   = vecs[i].start;
            bus.abort   = vecs[i].abort;
            bus.in_sel  = vecs[i].in_sel;
            bus.out_sel = vecs[i].out_sel;
            step();
            check($sformatf("v%0d ctrl_a", i), 16'(bus.ctrl_a), 16'(vecs[i].ctrl_a));
            check($sformatf("v%0d ctrl_s", i), 16'(bus.ctrl_s), 16'(vecs[i].ctrl_s));
            check($sformatf("v%0d pump_a", i), 16'(bus.pump_a), 16'(vecs[i].pump_a));
            check($sformatf("v%0d pump_b", i), 16'(bus.pump_b), 16'(vecs[i].pump_b));
            check($sformatf("v%0d busy", i),   16'(bus.busy),   16'(vecs[i].busy));
            check($sformatf("v%0d done", i),   16'(bus.done),   16'(vecs[i].done));
            check($sformatf("v%0d err", i),    16'(bus.err),    16'(vecs[i].err));
        end
        bus.start = 1'b0; bus.abort = 1'b0;

        // Busy window length and a single done pulse, bounded wait
        bus.start = 1'b1; bus.in_sel = 2'd1; bus.out_sel = 2'd2;
        step();
        bus.start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 200 && bus.busy; c++) begin
            busy_cnt++;
            if (bus.done) done_cnt++;
            step();
        end
        check("busy_fell", 16'(bus.busy), 16'(0));
        check("busy_len", 16'(busy_cnt), 16'(EXP_BUSY));
        check("done_pulses", 16'(done_cnt), 16'(1));

        // Async reset mid-LOAD: pads go safe with no clock edge
        bus.start = 1'b1; bus.in_sel = 2'd2; bus.out_sel = 2'd1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        check("mid_load ctrl_a", 16'(bus.ctrl_a), 16'(13'h1FFB));
        #2;
        rst_n = 1'b0;
        #1;
        check_pads("async_rst", 13'h1FFF, 3'b111, 2'b11, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_pads("after_rst", 13'h1FFF, 3'b111, 2'b11, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
